hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline's combinational hazard detection. It tracks destination registers of in-flight variable-latency (multi-cycle) operations such as divide and multi-cycle load. It stalls decode on RAW, WAW and structural hazards against them and keeps stall and timeout bookkeeping. It sits beside the existing hazard logic at the ID/EX boundary, and its `o_stall_d` / `o_bubble_e` are OR-ed into the PC stall, IF/ID stall and ID/EX flush.

---
 rtl/hazard_scoreboard_pkg.sv | 15 +
 rtl/hazard_scoreboard_sat_counter.sv | 25 ++
 rtl/hazard_scoreboard.sv | 133 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the multi-cycle hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_COUNT_DEFAULT  = 32;
  localparam int unsigned REG_ADDR_W_DEFAULT = 5;
  localparam int unsigned X0_IDX             = 0;
  localparam int unsigned TIMEOUT_DEFAULT    = 64;
  localparam int unsigned CNT_W_DEFAULT      = 16;

  // Bits needed to hold every value in 0..max_val inclusive.
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Up-counter that sticks at MAX_VAL; clr has priority over inc.
module sat_counter #(
  parameter int unsigned        WIDTH   = 8,
  parameter logic [WIDTH-1:0]   MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Clear, or step towards MAX_VAL and hold there.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != MAX_VAL)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard for in-flight multi-cycle ops: stalls decode on RAW/WAW/structural
// hazards against the outstanding op and keeps stall/timeout bookkeeping.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_COUNT  = REG_COUNT_DEFAULT,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid_d,
  input  logic [REG_ADDR_W-1:0] i_rs1_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_d,
  input  logic [REG_ADDR_W-1:0] i_rd_d,
  input  logic                  i_use_rs1_d,
  input  logic                  i_use_rs2_d,
  input  logic                  i_wr_d,
  input  logic                  i_mc_d,
  input  logic                  i_flush,
  input  logic                  i_mc_done,
  output logic                  o_stall_d,
  output logic                  o_bubble_e,
  output logic [REG_COUNT-1:0]  o_pending,
  output logic                  o_mc_busy,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic                  o_timeout
);

  localparam int unsigned AGE_W = cnt_bits(TIMEOUT);
  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(X0_IDX);

  // Bit lookup that reads as 0 for indices beyond REG_COUNT.
  function automatic logic bit_at(input logic [REG_COUNT-1:0]  vec,
                                  input logic [REG_ADDR_W-1:0] idx);
    bit_at = 1'b0;
    for (int unsigned k = 0; k < REG_COUNT; k++) begin
      if (idx == REG_ADDR_W'(k)) bit_at = vec[k];
    end
  endfunction

  function automatic logic [REG_COUNT-1:0] onehot(input logic [REG_ADDR_W-1:0] idx);
    onehot = '0;
    for (int unsigned k = 0; k < REG_COUNT; k++) begin
      if (idx == REG_ADDR_W'(k)) onehot[k] = 1'b1;
    end
  endfunction

  logic [REG_COUNT-1:0]  pending_q, pending_d;
  logic [REG_COUNT-1:0]  clr_mask, eff;
  logic                  busy_q, busy_d;
  logic [REG_ADDR_W-1:0] mc_rd_q, mc_rd_d;
  logic                  timeout_q, timeout_d;
  logic                  done, raw_hit, waw_hit, struct_hit, stall, issue;
  logic [AGE_W-1:0]      age;
  logic [CNT_W-1:0]      stall_cnt;

  // Hazard detection; a completing result is bypassed so its register is free now.
  always_comb begin
    done       = i_mc_done && busy_q;
    clr_mask   = done ? onehot(mc_rd_q) : '0;
    eff        = pending_q & ~clr_mask;
    raw_hit    = (i_use_rs1_d && (i_rs1_d != X0) && bit_at(eff, i_rs1_d)) ||
                 (i_use_rs2_d && (i_rs2_d != X0) && bit_at(eff, i_rs2_d));
    waw_hit    = i_wr_d && (i_rd_d != X0) && bit_at(eff, i_rd_d);
    struct_hit = i_mc_d && busy_q && !i_mc_done;
    stall      = i_valid_d && !i_flush && (raw_hit || waw_hit || struct_hit);
    issue      = i_valid_d && !i_flush && !stall && i_mc_d;
  end

  // Next state: completion clears first, then a same-cycle issue sets.
  always_comb begin
    pending_d = eff;
    if (issue && i_wr_d && (i_rd_d != X0)) begin
      pending_d = pending_d | onehot(i_rd_d);
    end
    pending_d[X0_IDX] = 1'b0;

    busy_d = busy_q;
    if (issue) begin
      busy_d = 1'b1;
    end else if (done) begin
      busy_d = 1'b0;
    end

    mc_rd_d   = issue ? i_rd_d : mc_rd_q;
    timeout_d = timeout_q || (busy_q && (age == AGE_W'(TIMEOUT - 1)));
  end

  // Scoreboard state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_q <= '0;
      busy_q    <= 1'b0;
      mc_rd_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
      mc_rd_q   <= mc_rd_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .WIDTH   (AGE_W),
    .MAX_VAL (AGE_W'(TIMEOUT))
  ) u_age_cnt (
    .clk   (i_clk),
    .clr   (i_rst || issue),
    .inc   (busy_q && !done),
    .count (age)
  );

  sat_counter #(
    .WIDTH   (CNT_W),
    .MAX_VAL ({CNT_W{1'b1}})
  ) u_stall_cnt (
    .clk   (i_clk),
    .clr   (i_rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  assign o_stall_d   = stall;
  assign o_bubble_e  = stall;
  assign o_pending   = pending_q;
  assign o_mc_busy   = busy_q;
  assign o_stall_cnt = stall_cnt;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed table, multi-cycle corner sequences,
// and randomized traffic against a single-outstanding-op reference model.
module tb_hazard_scoreboard;

  localparam int unsigned RC      = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned TO      = 4;
  localparam int unsigned CW      = 6;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_d, use1, use2, wr_d, mc_d, flush, mc_done;
  logic [AW-1:0] rs1, rs2, rd;
  logic          stall_d, bubble_e, mc_busy, timeout;
  logic [RC-1:0] pending;
  logic [CW-1:0] stall_cnt;

  hazard_scoreboard #(
    .REG_COUNT  (RC),
    .REG_ADDR_W (AW),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid_d   (valid_d),
    .i_rs1_d     (rs1),
    .i_rs2_d     (rs2),
    .i_rd_d      (rd),
    .i_use_rs1_d (use1),
    .i_use_rs2_d (use2),
    .i_wr_d      (wr_d),
    .i_mc_d      (mc_d),
    .i_flush     (flush),
    .i_mc_done   (mc_done),
    .o_stall_d   (stall_d),
    .o_bubble_e  (bubble_e),
    .o_pending   (pending),
    .o_mc_busy   (mc_busy),
    .o_stall_cnt (stall_cnt),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit [4:0] rs1, rs2, rd;
    bit       use1, use2, wr, mc, flush, done;
  } in_t;

  typedef struct {
    in_t       in;
    bit        stall;
    bit [31:0] pend;
    bit        busy;
    bit        tmo;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: at most one op outstanding.
  bit m_valid;
  int m_rd;
  bit m_wr;
  int m_age;
  bit m_tmo;
  int m_stalls;

  function automatic in_t mk(bit valid, bit [4:0] r1, bit [4:0] r2, bit [4:0] d, bit u1,
                             bit u2, bit w, bit m, bit f, bit dn);
    in_t x;
    x.valid = valid; x.rs1 = r1; x.rs2 = r2; x.rd = d; x.use1 = u1; x.use2 = u2;
    x.wr = w; x.mc = m; x.flush = f; x.done = dn;
    return x;
  endfunction

  function automatic vec_t mv(in_t x, bit st, bit [31:0] p, bit b, bit t);
    vec_t v;
    v.in = x; v.stall = st; v.pend = p; v.busy = b; v.tmo = t;
    return v;
  endfunction

  task automatic drive(input in_t x);
    valid_d = x.valid; rs1 = x.rs1; rs2 = x.rs2; rd = x.rd; use1 = x.use1;
    use2 = x.use2; wr_d = x.wr; mc_d = x.mc; flush = x.flush; mc_done = x.done;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic bit m_blocked(int r, bit dn);
    return m_valid && m_wr && (m_rd != 0) && !dn && (r == m_rd);
  endfunction

  function automatic bit m_stall(in_t x);
    bit dn, raw, waw, str;
    dn  = x.done && m_valid;
    raw = (x.use1 && m_blocked(int'(x.rs1), dn)) || (x.use2 && m_blocked(int'(x.rs2), dn));
    waw = x.wr && m_blocked(int'(x.rd), dn);
    str = x.mc && m_valid && !x.done;
    return x.valid && !x.flush && (raw || waw || str);
  endfunction

  function automatic bit [31:0] m_pend();
    return (m_valid && m_wr && (m_rd != 0)) ? (32'd1 << m_rd) : 32'd0;
  endfunction

  task automatic m_step(input in_t x, input bit st, input bit r);
    bit dn, iss;
    if (r) begin
      m_valid = 0; m_age = 0; m_tmo = 0; m_stalls = 0;
    end else begin
      dn  = x.done && m_valid;
      iss = x.valid && !x.flush && !st && x.mc;
      if (m_valid && (m_age >= int'(TO) - 1)) m_tmo = 1;
      if (st && (m_stalls < CNT_MAX)) m_stalls++;
      if (m_valid && !dn && (m_age < int'(TO))) m_age++;
      if (iss) begin
        m_valid = 1; m_rd = int'(x.rd); m_wr = x.wr; m_age = 0;
      end else if (dn) begin
        m_valid = 0;
      end
    end
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.valid = ($urandom_range(0, 3) != 0);
    x.rs1   = 5'($urandom_range(0, 3));
    x.rs2   = 5'($urandom_range(0, 3));
    x.rd    = 5'($urandom_range(0, 3));
    x.use1  = $urandom_range(0, 1) == 1;
    x.use2  = $urandom_range(0, 1) == 1;
    x.wr    = $urandom_range(0, 1) == 1;
    x.mc    = ($urandom_range(0, 3) == 0);
    x.flush = ($urandom_range(0, 7) == 0);
    x.done  = ($urandom_range(0, 3) == 0);
    return x;
  endfunction

  vec_t tbl[18];
  in_t  idle_in;

  initial begin
    idle_in = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle_in);

    //          valid rs1 rs2 rd u1 u2 wr mc fl dn   stall pend        busy tmo
    tbl[0]  = mv(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0), 0, 32'd0,      0, 0);
    tbl[1]  = mv(mk(1, 0, 0, 5,  0, 0, 1, 1, 0, 0), 0, 32'd1 << 5, 1, 0);
    tbl[2]  = mv(mk(1, 5, 0, 6,  1, 0, 1, 0, 0, 0), 1, 32'd1 << 5, 1, 0);
    tbl[3]  = mv(mk(1, 5, 0, 6,  1, 0, 1, 0, 0, 0), 1, 32'd1 << 5, 1, 0);
    tbl[4]  = mv(mk(1, 5, 0, 6,  1, 0, 1, 0, 0, 1), 0, 32'd0,      0, 0);
    tbl[5]  = mv(mk(1, 0, 0, 7,  0, 0, 1, 1, 0, 0), 0, 32'd1 << 7, 1, 0);
    tbl[6]  = mv(mk(1, 0, 0, 8,  0, 0, 1, 1, 0, 0), 1, 32'd1 << 7, 1, 0);
    tbl[7]  = mv(mk(1, 0, 0, 8,  0, 0, 1, 1, 0, 1), 0, 32'd1 << 8, 1, 0);
    tbl[8]  = mv(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1), 0, 32'd0,      0, 0);
    tbl[9]  = mv(mk(1, 0, 0, 0,  0, 0, 1, 1, 0, 0), 0, 32'd0,      1, 0);
    tbl[10] = mv(mk(1, 0, 0, 0,  1, 1, 1, 0, 0, 0), 0, 32'd0,      1, 0);
    tbl[11] = mv(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1), 0, 32'd0,      0, 0);
    tbl[12] = mv(mk(1, 0, 0, 9,  0, 0, 1, 1, 0, 0), 0, 32'd1 << 9, 1, 0);
    tbl[13] = mv(mk(1, 0, 9, 10, 0, 1, 1, 0, 1, 0), 0, 32'd1 << 9, 1, 0);
    tbl[14] = mv(mk(1, 0, 9, 10, 0, 1, 1, 0, 0, 0), 1, 32'd1 << 9, 1, 0);
    tbl[15] = mv(mk(1, 0, 0, 9,  0, 0, 1, 0, 0, 0), 1, 32'd1 << 9, 1, 0);
    tbl[16] = mv(mk(1, 0, 0, 9,  0, 0, 1, 1, 0, 1), 0, 32'd1 << 9, 1, 1);
    tbl[17] = mv(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1), 0, 32'd0,      0, 1);

    // Reset state.
    do_reset();
    #1;
    check("rst_stall", stall_d, 0);
    check("rst_bubble", bubble_e, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", mc_busy, 0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_tmo", timeout, 0);

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].in);
      #1;
      check($sformatf("tbl%0d_stall", i), stall_d, tbl[i].stall);
      check($sformatf("tbl%0d_bubble", i), bubble_e, tbl[i].stall);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
      check($sformatf("tbl%0d_busy", i), mc_busy, tbl[i].busy);
      check($sformatf("tbl%0d_tmo", i), timeout, tbl[i].tmo);
    end
    check("tbl_stall_cnt", stall_cnt, 5);

    // Timeout after TO busy cycles, sticky through a later done.
    do_reset();
    drive(mk(1, 0, 0, 3, 0, 0, 1, 1, 0, 0));
    @(posedge clk);
    #1;
    check("to_busy", mc_busy, 1);
    @(negedge clk);
    drive(idle_in);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("to_cycle%0d", k), timeout, (k == 4));
      @(negedge clk);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge clk);
    #1;
    check("to_sticky_done", timeout, 1);
    check("to_done_busy", mc_busy, 0);
    @(negedge clk);
    drive(idle_in);
    @(posedge clk);
    #1;
    check("to_sticky_idle", timeout, 1);

    // Stall counter saturation: 2^CW+3 stall cycles.
    do_reset();
    drive(mk(1, 0, 0, 3, 0, 0, 1, 1, 0, 0));
    @(negedge clk);
    drive(mk(1, 3, 0, 4, 1, 0, 1, 0, 0, 0));
    for (int s = 1; s <= CNT_MAX + 4; s++) begin
      #1;
      if (s == 1 || s == CNT_MAX + 4) check($sformatf("sat_stall%0d", s), stall_d, 1);
      @(posedge clk);
      #1;
      if (s == CNT_MAX - 1) check("sat_cnt_mid", stall_cnt, CNT_MAX - 1);
      @(negedge clk);
    end
    check("sat_cnt_full", stall_cnt, CNT_MAX);
    drive(mk(1, 3, 0, 4, 1, 0, 1, 0, 0, 1));
    #1;
    check("sat_release", stall_d, 0);
    @(posedge clk);
    #1;
    check("sat_cnt_hold", stall_cnt, CNT_MAX);

    // Randomized traffic with occasional mid-operation reset.
    do_reset();
    m_step(idle_in, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      in_t x;
      bit  r, st;
      @(negedge clk);
      x = rand_in();
      r = ($urandom_range(0, 199) == 0);
      drive(x);
      rst = r;
      #1;
      st = m_stall(x);
      check("rnd_stall", stall_d, st);
      check("rnd_bubble", bubble_e, st);
      m_step(x, st, r);
      @(posedge clk);
      #1;
      check("rnd_pending", pending, m_pend());
      check("rnd_busy", mc_busy, m_valid);
      check("rnd_cnt", stall_cnt, m_stalls);
      check("rnd_tmo", timeout, m_tmo);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
